// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the clock-gate enable controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IDLE_CNT = 2'd1,
    GATED    = 2'd2,
    WAKE     = 2'd3
  } state_e;

  // Number of bits needed to index v distinct values (ceil(log2(v))).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Activity/wake inputs and enable/status outputs of the clock-gate controller.
interface clk_gate_ctrl_if #(
  parameter int unsigned GCNT_W = 16
);
  logic              gate_en_i;
  logic              busy_i;
  logic              req_i;
  logic              en_ip_o;
  logic              clk_rdy_o;
  logic              gated_o;
  logic              wake_ack_o;
  logic [GCNT_W-1:0] gate_cnt_o;

  modport master (
    output gate_en_i, busy_i, req_i,
    input  en_ip_o, clk_rdy_o, gated_o, wake_ack_o, gate_cnt_o
  );

  modport slave (
    input  gate_en_i, busy_i, req_i,
    output en_ip_o, clk_rdy_o, gated_o, wake_ack_o, gate_cnt_o
  );
endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-detect / wake controller producing a glitch-free registered clock enable.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned IDLE_CYC = 16,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned GCNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  clk_gate_ctrl_if.slave  bus
);
  localparam int unsigned CNT_MAX = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
  localparam int unsigned CW      = clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYC);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          en_q, en_d;
  logic          rdy_q, rdy_d;
  logic          gated_q, gated_d;
  logic          ack_q, ack_d;
  logic          idle;
  logic          enter_gated;

  assign idle    = bus.gate_en_i & ~bus.busy_i & ~bus.req_i;
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      en_q    <= 1'b1;
      rdy_q   <= 1'b1;
      gated_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      gated_q <= gated_d;
      ack_q   <= ack_d;
    end
  end

  // Outputs are decoded from the next state so every flop switches on the same edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    en_d        = 1'b1;
    rdy_d       = 1'b1;
    gated_d     = 1'b0;
    enter_gated = 1'b0;

    case (state_q)
      RUN: begin
        if (idle) begin
          if (IDLE_CYC == 1) begin
            state_d = GATED;
            cnt_d   = '0;
          end else begin
            state_d = IDLE_CNT;
            cnt_d   = CW'(1);
          end
        end
      end
      IDLE_CNT: begin
        if (!idle) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_inc == IDLE_LAST) begin
          state_d = GATED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GATED: begin
        if (!idle) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (cnt_inc == WAKE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      GATED: begin
        en_d    = 1'b0;
        rdy_d   = 1'b0;
        gated_d = 1'b1;
      end
      WAKE:    rdy_d = 1'b0;
      default: ;
    endcase

    enter_gated = (state_d == GATED) && (state_q != GATED);
  end

  sat_cnt #(
    .W (GCNT_W)
  ) u_gate_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (enter_gated),
    .cnt_o (bus.gate_cnt_o)
  );

  assign bus.en_ip_o    = en_q;
  assign bus.clk_rdy_o  = rdy_q;
  assign bus.gated_o    = gated_q;
  assign bus.wake_ack_o = ack_q;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed scoreboard bench for clk_gate_ctrl: default config and a 1-cycle/2-bit config.
module tb_clk_gate_ctrl;

  typedef struct {
    string       tag;
    logic        en;
    logic        rdy;
    logic        gated;
    logic        ack;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  clk_gate_ctrl_if #(.GCNT_W(16)) bus_a ();
  clk_gate_ctrl_if #(.GCNT_W(2))  bus_b ();

  clk_gate_ctrl #(.IDLE_CYC(16), .WAKE_CYC(2), .GCNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  clk_gate_ctrl #(.IDLE_CYC(1), .WAKE_CYC(1), .GCNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input bit sel_b, input logic ge, input logic bz, input logic rq,
                      input logic e_en, input logic e_rdy, input logic e_gated,
                      input logic e_ack, input int e_cnt, input string tag);
    exp_t e;
    exp_t got;
    if (sel_b) begin
      bus_b.gate_en_i = ge; bus_b.busy_i = bz; bus_b.req_i = rq;
    end else begin
      bus_a.gate_en_i = ge; bus_a.busy_i = bz; bus_a.req_i = rq;
    end
    e.tag = tag; e.en = e_en; e.rdy = e_rdy; e.gated = e_gated; e.ack = e_ack;
    e.cnt = 16'(e_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (sel_b) begin
      got.en = bus_b.en_ip_o; got.rdy = bus_b.clk_rdy_o; got.gated = bus_b.gated_o;
      got.ack = bus_b.wake_ack_o; got.cnt = 16'(bus_b.gate_cnt_o);
    end else begin
      got.en = bus_a.en_ip_o; got.rdy = bus_a.clk_rdy_o; got.gated = bus_a.gated_o;
      got.ack = bus_a.wake_ack_o; got.cnt = bus_a.gate_cnt_o;
    end
    chk(e.tag, "en_ip", 16'(got.en), 16'(e.en));
    chk(e.tag, "clk_rdy", 16'(got.rdy), 16'(e.rdy));
    chk(e.tag, "gated", 16'(got.gated), 16'(e.gated));
    chk(e.tag, "wake_ack", 16'(got.ack), 16'(e.ack));
    chk(e.tag, "gate_cnt", got.cnt, e.cnt);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus_a.gate_en_i = 1'b1; bus_a.busy_i = 1'b0; bus_a.req_i = 1'b0;
    bus_b.gate_en_i = 1'b0; bus_b.busy_i = 1'b0; bus_b.req_i = 1'b0;

    // Reset held for two edges
    step(0, 1, 0, 0, 1, 1, 0, 0, 0, "reset0");
    step(0, 1, 0, 0, 1, 1, 0, 0, 0, "reset1");
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, "reset_b");
    rst = 1'b0;

    // Gating after 16 consecutive idle cycles
    for (int i = 1; i <= 16; i++)
      step(0, 1, 0, 0, i < 16, i < 16, i == 16, 0, (i == 16) ? 1 : 0, "gate_run");
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, 0, 1, 0, 1, "gate_hold");

    // Wake on request: en at k, rdy and one ack at k+2
    step(0, 1, 0, 1, 1, 0, 0, 0, 1, "wake_k");
    step(0, 1, 0, 1, 1, 0, 0, 0, 1, "wake_k1");
    step(0, 1, 0, 1, 1, 1, 0, 1, 1, "wake_k2");
    step(0, 1, 1, 0, 1, 1, 0, 0, 1, "wake_ack_once");

    // Busy at idle cycle 15 restarts the count
    for (int i = 1; i <= 14; i++)
      step(0, 1, 0, 0, 1, 1, 0, 0, 1, "intr_idle");
    step(0, 1, 1, 0, 1, 1, 0, 0, 1, "intr_busy");
    for (int i = 1; i <= 16; i++)
      step(0, 1, 0, 0, i < 16, i < 16, i == 16, 0, (i == 16) ? 2 : 1, "intr_regate");

    // Override: gate_en=0 wakes, then no re-gating for 100 cycles
    step(0, 0, 0, 0, 1, 0, 0, 0, 2, "ovr_wake");
    step(0, 0, 0, 0, 1, 0, 0, 0, 2, "ovr_wake1");
    step(0, 0, 0, 0, 1, 1, 0, 1, 2, "ovr_run");
    for (int i = 0; i < 100; i++)
      step(0, 0, 0, 0, 1, 1, 0, 0, 2, "ovr_hold");

    // Request while running: no ack; non-idle on final count wins
    step(0, 1, 0, 1, 1, 1, 0, 0, 2, "req_in_run");
    for (int i = 1; i <= 15; i++)
      step(0, 1, 0, 0, 1, 1, 0, 0, 2, "last_idle");
    step(0, 1, 0, 1, 1, 1, 0, 0, 2, "last_req_wins");

    // Busy and request together in GATED give a single wake
    for (int i = 1; i <= 16; i++)
      step(0, 1, 0, 0, i < 16, i < 16, i == 16, 0, (i == 16) ? 3 : 2, "dual_gate");
    step(0, 1, 1, 1, 1, 0, 0, 0, 3, "dual_wake");
    step(0, 1, 1, 1, 1, 0, 0, 0, 3, "dual_wake1");
    step(0, 1, 1, 1, 1, 1, 0, 1, 3, "dual_run");
    step(0, 1, 1, 0, 1, 1, 0, 0, 3, "dual_noack");

    // IDLE_CYC=1, WAKE_CYC=1, 2-bit counter saturates at 3
    for (int n = 1; n <= 5; n++) begin
      step(1, 1, 0, 0, 0, 0, 1, 0, (n < 3) ? n : 3, "sat_gate");
      step(1, 1, 0, 1, 1, 0, 0, 0, (n < 3) ? n : 3, "sat_wake");
      step(1, 1, 0, 1, 1, 1, 0, 1, (n < 3) ? n : 3, "sat_run");
    end
    step(1, 1, 0, 0, 0, 0, 1, 0, 3, "sat_gate6");
    step(1, 1, 0, 1, 1, 0, 0, 0, 3, "sat_wake6");

    // Reset in WAKE and in GATED
    rst = 1'b1;
    step(1, 1, 0, 1, 1, 1, 0, 0, 0, "rst_in_wake");
    rst = 1'b0;
    step(1, 1, 0, 0, 0, 0, 1, 0, 1, "post_rst_gate");
    rst = 1'b1;
    step(1, 1, 0, 0, 1, 1, 0, 0, 0, "rst_in_gated");
    rst = 1'b0;
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, "post_rst_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
